// File: rtl/m_ext_pkg.sv
// Shared definitions for the iterative M-extension divider.
// Holds the operation encoding, the controller state encoding and
// small decode helpers used by the divider top.
package m_ext_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'd0,
    OP_DIVU = 2'd1,
    OP_REM  = 2'd2,
    OP_REMU = 2'd3
  } m_div_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } m_div_state_t;

  function automatic logic op_is_signed(input m_div_op_t op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_is_rem(input m_div_op_t op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration on unsigned magnitudes.
// The quotient register doubles as the dividend shift register: its MSB
// feeds the partial remainder while the new quotient bit enters at the LSB.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] div_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;
  logic          fits;

  // Trial subtract on the widened partial remainder, keep it if non-negative.
  // The kept remainder is always below the divisor, so its top bit is zero.
  always_comb begin
    shifted = {rem_i, quo_i[XLEN-1]};
    trial   = shifted - {1'b0, div_i};
    fits    = ~trial[XLEN];
    rem_o   = fits ? trial[XLEN-1:0] : shifted[XLEN-1:0];
    quo_o   = {quo_i[XLEN-2:0], fits};
  end

endmodule

// File: rtl/m_divider.sv
// Iterative signed/unsigned divider (DIV, DIVU, REM, REMU).
// Optional macro M_DIV_EARLY_OUT_EN: divide-by-zero and signed overflow
// skip the iteration and complete in the cycle after acceptance.
//
// state   | meaning
// IDLE    | ready_o high, waiting for start_i
// CALC    | one restoring step per cycle, counter XLEN-1 down to 0
// FIX     | apply signs / divide-by-zero rule, register result_o
// DONE    | done_o high for this single cycle
module m_divider
  import m_ext_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            kill_i,
  output logic            ready_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

  m_div_state_t    state, state_nxt;
  logic [CW-1:0]   cnt;
  m_div_op_t       op_q;
  logic            sign_a, sign_b;
  logic [XLEN-1:0] quo, rem, div;
  logic [XLEN-1:0] step_quo, step_rem;

  m_div_op_t       op_in;
  logic            accept;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN-1:0] q_fix, r_fix, fix_result;
  logic            early_hit;

  div_step #(.XLEN(XLEN)) u_step (
    .rem_i (rem),
    .quo_i (quo),
    .div_i (div),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  assign ready_o = (state == ST_IDLE);
  assign accept  = (state == ST_IDLE) && start_i && !kill_i;

  // Operand decode: magnitudes are only taken for the signed operations.
  always_comb begin
    op_in = m_div_op_t'(op_i);
    a_neg = op_is_signed(op_in) && a_i[XLEN-1];
    b_neg = op_is_signed(op_in) && b_i[XLEN-1];
    a_mag = a_neg ? -a_i : a_i;
    b_mag = b_neg ? -b_i : b_i;
  end

`ifdef M_DIV_EARLY_OUT_EN
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
  logic            is_zero, is_ovf;
  logic [XLEN-1:0] early_result;

  // Special operands resolved directly from the raw inputs.
  always_comb begin
    is_zero      = (b_i == '0);
    is_ovf       = op_is_signed(op_in) && (a_i == MOST_NEG) && (b_i == '1);
    early_hit    = is_zero || is_ovf;
    early_result = '0;
    if (is_zero)     early_result = op_is_rem(op_in) ? a_i : '1;
    else if (is_ovf) early_result = op_is_rem(op_in) ? '0 : a_i;
  end
`else
  assign early_hit = 1'b0;
`endif

  // Sign correction; a zero divisor keeps the all-ones quotient unsigned-style
  // while the remainder naturally returns the original dividend.
  always_comb begin
    q_fix      = (div == '0) ? '1 : ((sign_a ^ sign_b) ? -quo : quo);
    r_fix      = sign_a ? -rem : rem;
    fix_result = op_is_rem(op_q) ? r_fix : q_fix;
  end

  // Next-state selection; kill_i always wins and returns to IDLE.
  always_comb begin
    state_nxt = state;
    if (kill_i) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start_i) state_nxt = early_hit ? ST_DONE : ST_CALC;
        ST_CALC: if (cnt == '0) state_nxt = ST_FIX;
        ST_FIX:  state_nxt = ST_DONE;
        ST_DONE: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      done_o <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_o <= (state_nxt == ST_DONE);
    end
  end

  // Operand capture, iteration datapath, step counter and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      op_q     <= OP_DIV;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      quo      <= '0;
      rem      <= '0;
      div      <= '0;
      result_o <= '0;
    end else if (accept) begin
      op_q   <= op_in;
      sign_a <= a_neg;
      sign_b <= b_neg;
      quo    <= a_mag;
      rem    <= '0;
      div    <= b_mag;
      cnt    <= CW'(XLEN - 1);
`ifdef M_DIV_EARLY_OUT_EN
      if (early_hit) result_o <= early_result;
`endif
    end else if (state == ST_CALC && !kill_i) begin
      quo <= step_quo;
      rem <= step_rem;
      if (cnt != '0) cnt <= cnt - CW'(1);
    end else if (state == ST_FIX && !kill_i) begin
      result_o <= fix_result;
    end
  end

endmodule

// File: tb/tb_m_divider.sv
// Self-checking bench for m_divider (XLEN=32). A behavioural model tracks
// the expected ready/done/result every cycle; directed cases pin literals.
module tb_m_divider;

  localparam int XLEN = 32;
`ifdef M_DIV_EARLY_OUT_EN
  localparam int LAT_SP = 1;
`else
  localparam int LAT_SP = 34;
`endif
  localparam int LAT_N = 34;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            start_i = 1'b0;
  logic [1:0]      op_i = 2'd0;
  logic [XLEN-1:0] a_i = '0;
  logic [XLEN-1:0] b_i = '0;
  logic            kill_i = 1'b0;
  logic            ready_o, done_o;
  logic [XLEN-1:0] result_o;

  int n_cmp = 0;
  int n_bad = 0;

  m_divider #(.XLEN(XLEN)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .kill_i   (kill_i),
    .ready_o  (ready_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the operation definitions.
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return (op >= 2'd2) ? a : 32'hFFFF_FFFF;
    if ((op == 2'd0 || op == 2'd2) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return (op == 2'd2) ? 32'd0 : a;
    case (op)
      2'd0:    return sa / sb;
      2'd1:    return a / b;
      2'd2:    return sa % sb;
      default: return a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return LAT_SP;
    if ((op == 2'd0 || op == 2'd2) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return LAT_SP;
    return LAT_N;
  endfunction

  // Model: busy from acceptance; done in the cycle after the lat-th edge.
  bit          m_busy = 1'b0;
  int          m_k = 0;
  int          m_lat = 0;
  logic [31:0] m_exp = '0;
  logic [31:0] m_held = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_k    <= 0;
      m_held <= '0;
    end else if (m_busy) begin
      if (kill_i || m_k == m_lat) begin
        m_busy <= 1'b0;
      end else begin
        m_k <= m_k + 1;
        if (m_k + 1 == m_lat) m_held <= m_exp;
      end
    end else if (start_i && !kill_i) begin
      m_busy <= 1'b1;
      m_k    <= 1;
      m_exp  <= ref_result(op_i, a_i, b_i);
      m_lat  <= ref_lat(op_i, a_i, b_i);
      if (ref_lat(op_i, a_i, b_i) == 1) m_held <= ref_result(op_i, a_i, b_i);
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    check("ready", {31'd0, ready_o}, {31'd0, !m_busy});
    check("done", {31'd0, done_o}, {31'd0, m_busy && (m_k == m_lat)});
    check("result", result_o, m_held);
  end

  task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_r, input int exp_lat);
    int n;
    bit got;
    @(posedge clk); #1;
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    n = 0; got = 1'b0;
    while (!got && n < 200) begin
      @(posedge clk); #1;
      start_i = 1'b0;
      n++;
      if (done_o) got = 1'b1;
    end
    check({name, "_seen"}, {31'd0, got}, 32'd1);
    check({name, "_lat"}, n, exp_lat);
    check({name, "_res"}, result_o, exp_r);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, ready_o}, 32'd1);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_result", result_o, 32'd0);
    rst_n = 1'b1;

    do_op("divu_100_7", 2'd1, 32'd100, 32'd7, 32'd14, LAT_N);
    do_op("remu_100_7", 2'd3, 32'd100, 32'd7, 32'd2, LAT_N);
    do_op("div_m7_2", 2'd0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LAT_N);
    do_op("rem_m7_2", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LAT_N);
    do_op("divu_5_0", 2'd1, 32'd5, 32'd0, 32'hFFFF_FFFF, LAT_SP);
    do_op("rem_5_0", 2'd2, 32'd5, 32'd0, 32'd5, LAT_SP);
    do_op("div_ovf", 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SP);
    do_op("rem_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, LAT_SP);
    do_op("div_m5_0", 2'd0, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, LAT_SP);
    do_op("rem_m5_0", 2'd2, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, LAT_SP);
    do_op("remu_m5_0", 2'd3, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, LAT_SP);

    // Kill ten cycles into an operation.
    @(posedge clk); #1;
    start_i = 1'b1; op_i = 2'd1; a_i = 32'd1000; b_i = 32'd3;
    repeat (10) begin @(posedge clk); #1; start_i = 1'b0; end
    kill_i = 1'b1;
    @(posedge clk); #1;
    kill_i = 1'b0;
    check("kill_ready", {31'd0, ready_o}, 32'd1);
    dones = 0;
    repeat (40) begin @(posedge clk); #1; if (done_o) dones++; end
    check("kill_no_done", dones, 0);
    do_op("divu_9_3", 2'd1, 32'd9, 32'd3, 32'd3, LAT_N);

    // Kill and start together in IDLE.
    @(posedge clk); #1;
    start_i = 1'b1; kill_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; kill_i = 1'b0;
    check("kill_beats_start", {31'd0, ready_o}, 32'd1);

    // start_i held high across an operation: one done, then re-accept.
    @(posedge clk); #1;
    start_i = 1'b1; op_i = 2'd1; a_i = 32'd50; b_i = 32'd5;
    dones = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done_o) begin
        dones++;
        check("hold_res1", result_o, 32'd10);
        a_i = 32'd77; b_i = 32'd7;
      end
    end
    start_i = 1'b0;
    check("hold_one_done", dones, 1);
    dones = 0;
    for (int i = 0; i < 60 && dones == 0; i++) begin
      @(posedge clk); #1;
      if (done_o) dones++;
    end
    check("hold_second_done", dones, 1);
    check("hold_res2", result_o, 32'd11);

    // Reset asserted mid-operation.
    @(posedge clk); #1;
    start_i = 1'b1; op_i = 2'd1; a_i = 32'd123; b_i = 32'd4;
    repeat (5) begin @(posedge clk); #1; start_i = 1'b0; end
    rst_n = 1'b0;
    #1;
    check("midrst_ready", {31'd0, ready_o}, 32'd1);
    check("midrst_result", result_o, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    dones = 0;
    repeat (40) begin @(posedge clk); #1; if (done_o) dones++; end
    check("midrst_no_done", dones, 0);

    // Randomized traffic checked by the model.
    repeat (3000) begin
      @(posedge clk); #1;
      start_i = ($urandom_range(0, 3) == 0);
      kill_i  = ($urandom_range(0, 99) == 0);
      op_i    = 2'($urandom_range(0, 3));
      a_i     = pick();
      b_i     = pick();
    end
    @(posedge clk); #1;
    start_i = 1'b0; kill_i = 1'b0;
    repeat (40) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/m_divider.md
M_DIVIDER -- requirements
Module: m_divider

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand and result width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port start_i  input  1  request; accepted only when ready_o=1.
REQ-005 SHALL have port op_i  input  2  operation: 0=DIV, 1=DIVU, 2=REM, 3=REMU.
REQ-006 SHALL have port a_i  input  XLEN  dividend.
REQ-007 SHALL have port b_i  input  XLEN  divisor.
REQ-008 SHALL have port kill_i  input  1  pipeline flush; aborts any operation in progress.
REQ-009 SHALL have port ready_o  output  1  high only in IDLE.
REQ-010 SHALL have port done_o  output  1  one-cycle pulse; result_o valid.
REQ-011 SHALL have port result_o  output  XLEN  quotient (DIV/DIVU) or remainder (REM/REMU).

Function
REQ-012 SHALL implement FSM IDLE -> CALC -> FIX -> DONE -> IDLE.
REQ-013 SHALL capture op_i, |a_i|, |b_i| and the operand signs in IDLE on the edge where start_i=1 and kill_i=0, then enter CALC; magnitudes are taken only for DIV/REM.
REQ-014 SHALL perform one radix-2 restoring step per CALC cycle over XLEN+1-bit partial remainder, with a down-counter from XLEN-1 to 0; CALC exits to FIX after exactly XLEN cycles.
REQ-015 SHALL, in FIX, negate the quotient when the signs differ (DIV) and give the remainder the dividend's sign (REM), and register result_o.
REQ-016 SHALL assert done_o for exactly the single DONE cycle, which begins XLEN+2 edges after the accepting edge.
REQ-017 SHALL return, for divide by zero: quotient all-ones, remainder = a_i (both signed and unsigned).
REQ-018 SHALL return, for signed overflow (a_i = most-negative, b_i = -1, DIV/REM): quotient = a_i, remainder = 0.
REQ-019 SHALL hold result_o stable from DONE until the next accepted start.
REQ-020 SHALL ignore start_i outside IDLE.
REQ-021 SHALL, when kill_i=1 in any state, go to IDLE on the next edge with no done_o; kill_i beats start_i in the same cycle.
REQ-022 SHALL keep ready_o combinationally equal to (state==IDLE).

Reset
REQ-023 SHALL, while rst_n=0, force state=IDLE, counter=0, result_o=0, done_o=0, and ready_o=1.
REQ-024 SHALL discard any operation in progress when reset is asserted mid-operation, with no done_o after release.

Configuration
REQ-025 SHALL support macro M_DIV_EARLY_OUT_EN.
REQ-026 With M_DIV_EARLY_OUT_EN defined, divide-by-zero and signed-overflow operations SHALL skip CALC and FIX: IDLE goes to DONE and done_o asserts 1 cycle after the accepting edge.
REQ-027 With M_DIV_EARLY_OUT_EN undefined, all operations SHALL take the full XLEN+2 latency, and the special-case results SHALL emerge from the normal datapath plus FIX rules.

Structure
REQ-028 SHALL place the op encoding enum (m_div_op_t) and the FSM state enum in shared package m_ext_pkg.
REQ-029 SHALL implement one restoring iteration (trial subtract, select, shift, quotient bit) as combinational sub-module div_step, instantiated once.

Verification
REQ-030 SHALL show that DIVU a=100 b=7 -> done_o at start+34 cycles, result 14; REMU same operands -> 2.
REQ-031 SHALL show that DIV a=0xFFFFFFF9 (-7) b=2 -> 0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1).
REQ-032 SHALL show that DIVU a=5 b=0 -> 0xFFFFFFFF; REM a=5 b=0 -> 5, with latency 1 if M_DIV_EARLY_OUT_EN else 34.
REQ-033 SHALL show that DIV a=0x80000000 b=0xFFFFFFFF -> 0x80000000; REM -> 0.
REQ-034 SHALL show that kill_i pulsed 10 cycles after start -> ready_o=1 next cycle, no done_o; a following DIVU 9/3 -> 3.
REQ-035 SHALL show that start_i held high throughout an operation -> exactly one done_o, and the next operation is accepted in IDLE after DONE.
